rf_wb_ctrl: RTL and testbench

RF_WB_CTRL -- requirements
Module: rf_wb_ctrl

---
 rtl/rf_wb_ctrl_pkg.sv | 16 +
 rtl/rf_wb_ctrl_if.sv | 44 ++++
 rtl/rf_wb_ctrl_arb2.sv | 62 ++++++
 rtl/rf_wb_ctrl.sv | 94 +++++++++
 tb/tb_rf_wb_ctrl.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/rf_wb_ctrl_pkg.sv
// Shared definitions for the register-file write-back controller: default
// data width, register count and the 2-bit register-index type that the
// register file also uses.
package rf_pkg;

  localparam int WIDTH      = 16;
  localparam int NREGISTERS = 4;
  localparam int IDX_W      = 2;

  typedef logic [IDX_W-1:0] reg_idx_t;

  // Requester slots on the two-way arbiter; slot 0 is favoured after reset.
  localparam int SRC_LD  = 0;
  localparam int SRC_ALU = 1;

endpackage

// File: rtl/rf_wb_ctrl_if.sv
// Bundle of the write-back controller's handshake, issue and register-file
// write-port signals. The slave modport is the controller; the master
// modport is the side that owns the result sources and the issue stage.
interface rf_wb_ctrl_if;
  import rf_pkg::*;

  logic                  alu_valid;
  logic                  alu_ready;
  reg_idx_t              alu_rd;
  logic [WIDTH-1:0]      alu_data;

  logic                  ld_valid;
  logic                  ld_ready;
  reg_idx_t              ld_rd;
  logic [WIDTH-1:0]      ld_data;

  logic                  hold;

  logic                  issue_valid;
  reg_idx_t              issue_rd;

  logic                  wb_en;
  reg_idx_t              wb_rd;
  logic [WIDTH-1:0]      wb_data;

  logic [NREGISTERS-1:0] pending;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data,
    input  hold, issue_valid, issue_rd,
    output alu_ready, ld_ready,
    output wb_en, wb_rd, wb_data, pending
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data,
    output hold, issue_valid, issue_rd,
    input  alu_ready, ld_ready,
    input  wb_en, wb_rd, wb_data, pending
  );

endinterface

// File: rtl/rf_wb_ctrl_arb2.sv
// Two-way grant arbiter for the write-back port. req[0] is the load unit,
// req[1] the ALU. Define RF_WB_CTRL_RR_EN for round-robin arbitration with an
// internal pointer; otherwise the load unit has fixed priority and the block
// is purely combinational.
module rf_wb_arb2
  import rf_pkg::*;
(
`ifdef RF_WB_CTRL_RR_EN
  input  logic       clk,
  input  logic       rstz,
`endif
  input  logic [1:0] req,
  input  logic       hold,
  output logic [1:0] gnt
);

`ifdef RF_WB_CTRL_RR_EN
  // ptr_reg = 0 favours the load unit, 1 favours the ALU.
  logic ptr_reg;
  logic ptr_next;

  // Grant the single requester, or on conflict the one not granted last.
  always_comb begin
    gnt      = 2'b00;
    ptr_next = ptr_reg;
    if (!hold) begin
      if (req[SRC_LD] && (!req[SRC_ALU] || !ptr_reg)) begin
        gnt = 2'b01;
      end else if (req[SRC_ALU]) begin
        gnt = 2'b10;
      end
      if (gnt[SRC_LD]) begin
        ptr_next = 1'b1;
      end else if (gnt[SRC_ALU]) begin
        ptr_next = 1'b0;
      end
    end
  end

  // Pointer only moves when something is actually granted.
  always_ff @(posedge clk) begin
    if (!rstz) begin
      ptr_reg <= 1'b0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end
`else
  // Fixed priority: load unit first, ALU only when the load unit is idle.
  always_comb begin
    gnt = 2'b00;
    if (!hold) begin
      if (req[SRC_LD]) begin
        gnt = 2'b01;
      end else if (req[SRC_ALU]) begin
        gnt = 2'b10;
      end
    end
  end
`endif

endmodule

// File: rtl/rf_wb_ctrl.sv
// Register-file write-back controller: arbitrates ALU and load results onto
// a single registered write port and tracks which destinations still have a
// write outstanding. Optional feature macro: RF_WB_CTRL_RR_EN (round-robin
// arbitration instead of fixed load-first priority).
module rf_wb_ctrl
  import rf_pkg::reg_idx_t;
  import rf_pkg::SRC_LD;
  import rf_pkg::SRC_ALU;
#(
  parameter int WIDTH      = rf_pkg::WIDTH,
  parameter int NREGISTERS = rf_pkg::NREGISTERS
) (
  input  logic         clk,
  input  logic         rstz,
  inout  wire          dvdd,
  inout  wire          dgnd,
  rf_wb_ctrl_if.slave  bus
);

  logic [1:0]            req;
  logic [1:0]            gnt;
  logic                  arb_hold;

  logic                  wb_en_reg;
  reg_idx_t              wb_rd_reg;
  logic [WIDTH-1:0]      wb_data_reg;
  logic [NREGISTERS-1:0] pending_reg;
  logic [NREGISTERS-1:0] pending_next;

  // Supply pins carry no logic; they are only observed here so they count
  // as connected.
  logic unused_supply;
  assign unused_supply = dvdd ^ dgnd;

  // Reset blocks grants the same way hold does, so ready is low during
  // reset and nothing in flight is accepted on a reset edge.
  assign req      = {bus.alu_valid, bus.ld_valid};
  assign arb_hold = bus.hold | ~rstz;

  rf_wb_arb2 u_arb (
`ifdef RF_WB_CTRL_RR_EN
    .clk  (clk),
    .rstz (rstz),
`endif
    .req  (req),
    .hold (arb_hold),
    .gnt  (gnt)
  );

  assign bus.ld_ready  = gnt[SRC_LD];
  assign bus.alu_ready = gnt[SRC_ALU];

  // Register the accepted result; rd/data hold their value on idle cycles.
  always_ff @(posedge clk) begin
    if (!rstz) begin
      wb_en_reg   <= 1'b0;
      wb_rd_reg   <= '0;
      wb_data_reg <= '0;
    end else begin
      wb_en_reg <= |gnt;
      if (gnt[SRC_LD]) begin
        wb_rd_reg   <= bus.ld_rd;
        wb_data_reg <= bus.ld_data;
      end else if (gnt[SRC_ALU]) begin
        wb_rd_reg   <= bus.alu_rd;
        wb_data_reg <= bus.alu_data;
      end
    end
  end

  // Per-register scoreboard bit: a new issue beats the retiring write.
  for (genvar gi = 0; gi < NREGISTERS; gi++) begin : g_pend
    logic set_bit;
    logic clr_bit;
    assign set_bit          = bus.issue_valid && (bus.issue_rd == reg_idx_t'(gi));
    assign clr_bit          = wb_en_reg && (wb_rd_reg == reg_idx_t'(gi));
    assign pending_next[gi] = set_bit | (pending_reg[gi] & ~clr_bit);
  end

  // Scoreboard state register.
  always_ff @(posedge clk) begin
    if (!rstz) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  assign bus.wb_en   = wb_en_reg;
  assign bus.wb_rd   = wb_rd_reg;
  assign bus.wb_data = wb_data_reg;
  assign bus.pending = pending_reg;

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Self-checking bench for rf_wb_ctrl: directed scenarios followed by random
// traffic, all compared against a transaction-level model of the write-back
// port and the pending scoreboard. Honors RF_WB_CTRL_RR_EN for arbitration.
module tb_rf_wb_ctrl;
  import rf_pkg::*;

  logic clk  = 1'b0;
  logic rstz = 1'b0;
  wire  dvdd;
  wire  dgnd;
  assign dvdd = 1'b1;
  assign dgnd = 1'b0;

  always #5 clk = ~clk;

  rf_wb_ctrl_if bus ();

  rf_wb_ctrl #(.WIDTH(16), .NREGISTERS(4)) dut (
    .clk  (clk),
    .rstz (rstz),
    .dvdd (dvdd),
    .dgnd (dgnd),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  // Model state: what the write port and scoreboard should show.
  logic        m_wb_en;
  logic [1:0]  m_wb_rd;
  logic [15:0] m_wb_data;
  logic [3:0]  m_pending;
  int          m_last;      // source granted most recently: 0 load, 1 ALU
  int          exp_grant;   // -1 none, 0 load, 1 ALU
  logic        saw_1234;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Who should win this cycle, from the arbitration rules alone.
  function automatic int pick();
    if (!rstz || bus.hold) return -1;
    if (bus.ld_valid && !bus.alu_valid) return 0;
    if (bus.alu_valid && !bus.ld_valid) return 1;
    if (!bus.ld_valid && !bus.alu_valid) return -1;
`ifdef RF_WB_CTRL_RR_EN
    return (m_last == 0) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  task automatic idle();
    bus.alu_valid   = 1'b0;
    bus.ld_valid    = 1'b0;
    bus.hold        = 1'b0;
    bus.issue_valid = 1'b0;
  endtask

  // One clock: check ready before the edge, update the model, check outputs.
  task automatic cycle(input string tag);
    exp_grant = pick();
    #1;
    chk({tag, ".ld_ready"},  {31'd0, bus.ld_ready},  {31'd0, exp_grant == 0});
    chk({tag, ".alu_ready"}, {31'd0, bus.alu_ready}, {31'd0, exp_grant == 1});
    @(posedge clk);
    if (!rstz) begin
      m_wb_en = 1'b0; m_wb_rd = 2'd0; m_wb_data = 16'd0; m_pending = 4'd0; m_last = 1;
    end else begin
      if (m_wb_en) m_pending[m_wb_rd] = 1'b0;
      if (bus.issue_valid) m_pending[bus.issue_rd] = 1'b1;
      m_wb_en = (exp_grant >= 0);
      if (exp_grant == 0) begin
        m_wb_rd = bus.ld_rd; m_wb_data = bus.ld_data; m_last = 0;
        $display("txn %s src=LD rd=%0d data=%h", tag, bus.ld_rd, bus.ld_data);
      end else if (exp_grant == 1) begin
        m_wb_rd = bus.alu_rd; m_wb_data = bus.alu_data; m_last = 1;
        $display("txn %s src=ALU rd=%0d data=%h", tag, bus.alu_rd, bus.alu_data);
      end
    end
    #1;
    chk({tag, ".wb_en"},   {31'd0, bus.wb_en},   {31'd0, m_wb_en});
    chk({tag, ".wb_rd"},   {30'd0, bus.wb_rd},   {30'd0, m_wb_rd});
    chk({tag, ".wb_data"}, {16'd0, bus.wb_data}, {16'd0, m_wb_data});
    chk({tag, ".pending"}, {28'd0, bus.pending}, {28'd0, m_pending});
    if (bus.wb_en && bus.wb_data == 16'h1234) saw_1234 = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    idle();
    bus.alu_rd = 2'd0; bus.alu_data = 16'd0;
    bus.ld_rd  = 2'd0; bus.ld_data  = 16'd0;
    bus.issue_rd = 2'd0;
    m_last = 1; saw_1234 = 1'b0;

    // Reset state.
    rstz = 1'b0;
    cycle("reset0");
    cycle("reset1");
    chk("reset.pending", {28'd0, bus.pending}, 32'd0);
    rstz = 1'b1;
    cycle("post_reset");

    // Single ALU write.
    bus.alu_valid = 1'b1; bus.alu_rd = 2'd2; bus.alu_data = 16'hBEEF;
    cycle("alu_single");
    chk("alu_single.data", {16'd0, bus.wb_data}, 32'h0000BEEF);
    idle();
    cycle("alu_single_after");
    chk("alu_single_after.en", {31'd0, bus.wb_en}, 32'd0);

    // Conflict for four cycles.
    bus.ld_valid = 1'b1; bus.ld_rd = 2'd1;
    bus.alu_valid = 1'b1; bus.alu_rd = 2'd3;
    for (int i = 0; i < 4; i++) begin
      bus.ld_data  = 16'hA000 + 16'(i);
      bus.alu_data = 16'hC000 + 16'(i);
      cycle($sformatf("conflict%0d", i));
`ifdef RF_WB_CTRL_RR_EN
      chk($sformatf("conflict%0d.rd", i), {30'd0, bus.wb_rd}, (i % 2 == 0) ? 32'd1 : 32'd3);
`else
      chk($sformatf("conflict%0d.rd", i), {30'd0, bus.wb_rd}, 32'd1);
`endif
    end
    idle();
    cycle("conflict_drain");

    // Hold blocks the load unit for three cycles.
    bus.ld_valid = 1'b1; bus.ld_rd = 2'd0; bus.ld_data = 16'h5A5A; bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) cycle($sformatf("hold%0d", i));
    bus.hold = 1'b0;
    cycle("hold_release");
    chk("hold_release.en", {31'd0, bus.wb_en}, 32'd1);
    idle();
    cycle("hold_drain");

    // Scoreboard set, clear, and set winning over clear.
    bus.issue_valid = 1'b1; bus.issue_rd = 2'd1;
    cycle("sb_issue");
    chk("sb_issue.pending", {28'd0, bus.pending}, 32'b0010);
    idle();
    bus.alu_valid = 1'b1; bus.alu_rd = 2'd1; bus.alu_data = 16'h0101;
    cycle("sb_write");
    idle();
    cycle("sb_clear");
    chk("sb_clear.pending", {28'd0, bus.pending}, 32'd0);
    bus.issue_valid = 1'b1; bus.issue_rd = 2'd1;
    cycle("sb_issue2");
    idle();
    bus.alu_valid = 1'b1; bus.alu_rd = 2'd1; bus.alu_data = 16'h0202;
    cycle("sb_write2");
    idle();
    bus.issue_valid = 1'b1; bus.issue_rd = 2'd1;
    cycle("sb_set_wins");
    chk("sb_set_wins.pending", {28'd0, bus.pending}, 32'b0010);
    idle();

    // Reset lands on the edge that would accept 16'h1234.
    saw_1234 = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_rd = 2'd0; bus.alu_data = 16'h1234;
    rstz = 1'b0;
    cycle("rst_mid");
    chk("rst_mid.pending", {28'd0, bus.pending}, 32'd0);
    rstz = 1'b1;
    idle();
    for (int i = 0; i < 3; i++) cycle($sformatf("rst_after%0d", i));
    chk("rst_mid.no_1234", {31'd0, saw_1234}, 32'd0);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      bus.ld_valid    = 1'($urandom_range(0, 1));
      bus.alu_valid   = 1'($urandom_range(0, 1));
      bus.ld_rd       = 2'($urandom);
      bus.alu_rd      = 2'($urandom);
      bus.ld_data     = 16'($urandom);
      bus.alu_data    = 16'($urandom);
      bus.hold        = ($urandom_range(0, 7) == 0);
      bus.issue_valid = 1'($urandom_range(0, 1));
      bus.issue_rd    = 2'($urandom);
      rstz            = ($urandom_range(0, 49) != 0);
      cycle($sformatf("rand%0d", i));
    end
    rstz = 1'b1;
    idle();
    cycle("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
